bp_fe_ras_stack: RTL and testbench
==================================

# bp_fe_ras_stack

Parametrised, multi-entry return address stack (RAS) for the front end. It replaces the single-register return-address predictor in PC generation with a circular stack of configurable depth, and adds speculative checkpoint/restore for recovery on backend redirects. It sits beside PC generation:

- Fetch-side call/return scans push and pop.
- The top entry feeds the return-override target.
- A checkpoint travels with branch metadata, and the backend resolution path restores it on a mispredict.

## Interface
Parameters:
- vaddr_width_p, 39, virtual address width of stored return addresses
- ras_depth_p, 8, number of entries; power of two, ≥2
- ras_ptr_width_lp, $clog2(ras_depth_p), derived, pointer width
- ras_cnt_width_lp, $clog2(ras_depth_p+1), derived, occupancy width
- ras_ckpt_width_lp, ras_cnt_width_lp+ras_ptr_width_lp+vaddr_width_p, derived

Ports:
- clk_i  in  1  single clock; all state updates on posedge
- reset_n_i  in  1  asynchronous, active-low reset
- push_v_i  in  1  call seen; push push_addr_i
- push_addr_i  in  vaddr_width_p  return address (call PC + 4)
- pop_v_i  in  1  return seen; pop top
- restore_v_i  in  1  restore state from restore_ckpt_i
- restore_ckpt_i  in  ras_ckpt_width_lp  checkpoint previously taken from ckpt_o
- top_addr_o  out  vaddr_width_p  predicted return address
- top_v_o  out  1  stack non-empty
- ckpt_o  out  ras_ckpt_width_lp  current {count, ptr, top_addr}

## Operation
State:
- mem[ras_depth_p]
- ptr: next free slot
- count: valid entries, saturating at ras_depth_p

Outputs:
- top = mem[ptr-1], with ptr arithmetic modulo ras_depth_p; wrap 0 → depth-1 is natural truncation.
- top_addr_o = top when count≠0, else 0.
- top_v_o = (count≠0).
- ckpt_o = {count, ptr, top_addr_o}.

Per-cycle update, in priority order:
- restore_v_i:
  - ptr ← ckpt.ptr; count ← ckpt.count.
  - If ckpt.count≠0, mem[ckpt.ptr-1] ← ckpt.top_addr. This repairs an entry overwritten on the wrong path.
  - push_v_i and pop_v_i are ignored this cycle.
- push_v_i & pop_v_i (coroutine jalr):
  - If count≠0: mem[ptr-1] ← push_addr_i; ptr and count unchanged.
  - If count=0: treat as push only.
- push_v_i only:
  - mem[ptr] ← push_addr_i; ptr ← ptr+1; count ← min(count+1, ras_depth_p).
  - Overflow: when full, this overwrites the oldest entry. count stays ras_depth_p. No error is raised.
- pop_v_i only:
  - If count≠0: ptr ← ptr-1; count ← count-1.
  - Underflow: when empty, nothing changes and the stack stays empty.
- None asserted: hold.

Reset (reset_n_i=0, asynchronous):
- ptr=0, count=0, all mem entries 0.
- top_addr_o=0, top_v_o=0, ckpt_o=0.
- Takes effect immediately, mid-operation included. Any in-flight push/pop/restore is discarded.

## Timing
- All outputs are combinational from registered state only. There is no input-to-output combinational path.
- Push/pop/restore at cycle N become visible on top_addr_o/top_v_o/ckpt_o in cycle N+1. Latency is 1 cycle.
- No handshake: every request is accepted in the cycle it is asserted, with no backpressure.
- The caller must capture ckpt_o in the same cycle as the fetch it tags.
- Deassertion of reset_n_i is synchronised externally. The first update occurs on the first posedge with reset_n_i=1.

## Structure
- bp_fe_pkg holds a struct macro for the checkpoint, {count, ptr, top_addr}: declare_bp_fe_ras_ckpt_s(vaddr_width_p, ras_depth_p). Include it in branch metadata width accounting.
- mem is a flop array: it needs a reset and a same-cycle write/read-next. No SRAM.
- No sub-module needed. The pointer/count next-state logic fits in one always_comb, with one always_ff on negedge reset_n_i.

## Test plan
Use ras_depth_p=4, vaddr_width_p=39.
1. Reset, then push 0x100, 0x200 over consecutive cycles → top_addr_o=0x200, top_v_o=1, count=2. Pop → 0x100. Pop → top_v_o=0, top_addr_o=0. Third pop → no change.
2. Overflow: push 0x10, 0x20, 0x30, 0x40, 0x50 → count=4, top=0x50. Four pops yield 0x50, 0x40, 0x30, 0x20, then empty; 0x10 is lost.
3. Simultaneous push+pop with stack {0x10, 0x20} → top=0x99, count=2. On an empty stack, the same stimulus → top=0x99, count=1.
4. Checkpoint repair:
   - Stack {0x10, 0x20}; capture ckpt_o.
   - Pop, then push 0xBAD, which overwrites slot 1.
   - Restore the checkpoint → top=0x20, count=2. Next pop → 0x10.
5. Restore priority: restore_v_i, push_v_i and pop_v_i asserted together → state equals the checkpoint exactly; the push address is not written.
6. Asynchronous reset: assert reset_n_i mid-cycle between clock edges while count=3 → outputs read 0 before the next posedge. After release, first push 0x40 → count=1, top=0x40.

Source files
------------

// File: rtl/bp_fe_ras_stack_pkg.sv
// Shared types for the front-end return address stack: checkpoint layout
// (used in branch metadata width accounting) and the per-cycle operation code.
`ifndef BP_FE_RAS_STACK_PKG_SV
`define BP_FE_RAS_STACK_PKG_SV

`define DECLARE_BP_FE_RAS_CKPT_S(vaddr_width_mp, ras_depth_mp) \
    typedef struct packed { \
        logic [$clog2((ras_depth_mp)+1)-1:0] count; \
        logic [$clog2(ras_depth_mp)-1:0]     ptr; \
        logic [(vaddr_width_mp)-1:0]         top_addr; \
    } bp_fe_ras_ckpt_s

package bp_fe_ras_stack_pkg;

    typedef enum logic [2:0] {
        RAS_HOLD    = 3'd0,
        RAS_PUSH    = 3'd1,
        RAS_POP     = 3'd2,
        RAS_REPLACE = 3'd3,
        RAS_RESTORE = 3'd4
    } ras_op_e;

    function automatic int ras_ckpt_width(input int vaddr_width, input int ras_depth);
        return $clog2(ras_depth + 1) + $clog2(ras_depth) + vaddr_width;
    endfunction

endpackage

`endif

// File: rtl/bp_fe_ras_stack.sv
// Circular return address stack with speculative checkpoint/restore.
// Outputs depend on registered state only; updates land one cycle later.
module bp_fe_ras_stack
    import bp_fe_ras_stack_pkg::*;
#(
    parameter  int vaddr_width_p     = 39,
    parameter  int ras_depth_p       = 8,
    localparam int ras_ptr_width_lp  = $clog2(ras_depth_p),
    localparam int ras_cnt_width_lp  = $clog2(ras_depth_p + 1),
    localparam int ras_ckpt_width_lp = ras_ckpt_width(vaddr_width_p, ras_depth_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         push_v_i,
    input  logic [vaddr_width_p-1:0]     push_addr_i,
    input  logic                         pop_v_i,
    input  logic                         restore_v_i,
    input  logic [ras_ckpt_width_lp-1:0] restore_ckpt_i,
    output logic [vaddr_width_p-1:0]     top_addr_o,
    output logic                         top_v_o,
    output logic [ras_ckpt_width_lp-1:0] ckpt_o
);

    `DECLARE_BP_FE_RAS_CKPT_S(vaddr_width_p, ras_depth_p);

    localparam logic [ras_ptr_width_lp-1:0] ptr_one_lp  = ras_ptr_width_lp'(1);
    localparam logic [ras_cnt_width_lp-1:0] cnt_one_lp  = ras_cnt_width_lp'(1);
    localparam logic [ras_cnt_width_lp-1:0] cnt_full_lp = ras_cnt_width_lp'(ras_depth_p);

    logic [vaddr_width_p-1:0]    mem_reg [ras_depth_p];
    logic [ras_ptr_width_lp-1:0] ptr_reg, ptr_next;
    logic [ras_cnt_width_lp-1:0] count_reg, count_next;

    ras_op_e                     op;
    logic                        wr_en;
    logic [ras_ptr_width_lp-1:0] wr_idx;
    logic [vaddr_width_p-1:0]    wr_data;
    logic [ras_depth_p-1:0]      wr_sel;
    logic [ras_ptr_width_lp-1:0] top_idx;
    logic [ras_ptr_width_lp-1:0] restore_top_idx;
    bp_fe_ras_ckpt_s             restore_ckpt;

    assign restore_ckpt    = restore_ckpt_i;
    assign top_idx         = ptr_reg - ptr_one_lp;
    assign restore_top_idx = restore_ckpt.ptr - ptr_one_lp;

    always_comb begin
        op = RAS_HOLD;
        if (restore_v_i) begin
            op = RAS_RESTORE;
        end else if (push_v_i && pop_v_i && (count_reg != '0)) begin
            op = RAS_REPLACE;
        end else if (push_v_i) begin
            op = RAS_PUSH;
        end else if (pop_v_i && (count_reg != '0)) begin
            op = RAS_POP;
        end
    end

    always_comb begin
        ptr_next   = ptr_reg;
        count_next = count_reg;
        wr_en      = 1'b0;
        wr_idx     = ptr_reg;
        wr_data    = push_addr_i;
        unique case (op)
            RAS_RESTORE: begin
                // Re-write the checkpointed top in case a wrong-path push clobbered it
                ptr_next   = restore_ckpt.ptr;
                count_next = restore_ckpt.count;
                wr_en      = (restore_ckpt.count != '0);
                wr_idx     = restore_top_idx;
                wr_data    = restore_ckpt.top_addr;
            end
            RAS_REPLACE: begin
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end
            RAS_PUSH: begin
                wr_en      = 1'b1;
                ptr_next   = ptr_reg + ptr_one_lp;
                count_next = (count_reg == cnt_full_lp) ? cnt_full_lp : count_reg + cnt_one_lp;
            end
            RAS_POP: begin
                ptr_next   = top_idx;
                count_next = count_reg - cnt_one_lp;
            end
            default: begin
            end
        endcase
    end

    for (genvar gi = 0; gi < ras_depth_p; gi++) begin : g_wr_sel
        assign wr_sel[gi] = wr_en && (wr_idx == ras_ptr_width_lp'(gi));
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < ras_depth_p; i++) begin
                mem_reg[i] <= '0;
            end
            ptr_reg   <= '0;
            count_reg <= '0;
        end else begin
            for (int i = 0; i < ras_depth_p; i++) begin
                if (wr_sel[i]) begin
                    mem_reg[i] <= wr_data;
                end
            end
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
        end
    end

    assign top_v_o    = (count_reg != '0);
    assign top_addr_o = top_v_o ? mem_reg[top_idx] : '0;
    assign ckpt_o     = {count_reg, ptr_reg, top_addr_o};

endmodule

// File: tb/tb_bp_fe_ras_stack.sv
// Directed bench for bp_fe_ras_stack at depth 4, 39-bit addresses.
module tb_bp_fe_ras_stack;

    localparam int VW = 39;
    localparam int CW = 44;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          push_v_i;
    logic [VW-1:0] push_addr_i;
    logic          pop_v_i;
    logic          restore_v_i;
    logic [CW-1:0] restore_ckpt_i;
    logic [VW-1:0] top_addr_o;
    logic          top_v_o;
    logic [CW-1:0] ckpt_o;

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] saved_ckpt;

    bp_fe_ras_stack #(
        .vaddr_width_p(VW),
        .ras_depth_p  (4)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .push_v_i      (push_v_i),
        .push_addr_i   (push_addr_i),
        .pop_v_i       (pop_v_i),
        .restore_v_i   (restore_v_i),
        .restore_ckpt_i(restore_ckpt_i),
        .top_addr_o    (top_addr_o),
        .top_v_o       (top_v_o),
        .ckpt_o        (ckpt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One request per cycle; inputs change 1 time unit after the edge.
    task automatic op(input logic pu, input logic po, input logic rs,
                      input logic [VW-1:0] a, input logic [CW-1:0] ck);
        push_v_i       = pu;
        pop_v_i        = po;
        restore_v_i    = rs;
        push_addr_i    = a;
        restore_ckpt_i = ck;
        @(posedge clk_i);
        #1;
        push_v_i       = 1'b0;
        pop_v_i        = 1'b0;
        restore_v_i    = 1'b0;
        push_addr_i    = '0;
        restore_ckpt_i = '0;
    endtask

    task automatic push(input logic [VW-1:0] a);
        op(1'b1, 1'b0, 1'b0, a, '0);
    endtask

    task automatic pop();
        op(1'b0, 1'b1, 1'b0, '0, '0);
    endtask

    function automatic logic [CW-1:0] mk(input int cnt, input int ptr, input logic [VW-1:0] top);
        logic [2:0] c3;
        logic [1:0] p2;
        c3 = cnt[2:0];
        p2 = ptr[1:0];
        return {c3, p2, top};
    endfunction

    initial begin
        reset_n_i = 1'b0;
        push_v_i = 1'b0; pop_v_i = 1'b0; restore_v_i = 1'b0;
        push_addr_i = '0; restore_ckpt_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_top_addr", 64'(top_addr_o), 64'h0);
        check("reset_top_v",    64'(top_v_o),    64'h0);
        check("reset_ckpt",     64'(ckpt_o),     64'h0);
        reset_n_i = 1'b1;

        // 1. basic push/pop and underflow
        push(39'h100);
        check("t1_first_push", 64'(ckpt_o), 64'(mk(1, 1, 39'h100)));
        push(39'h200);
        check("t1_push2_ckpt", 64'(ckpt_o), 64'(mk(2, 2, 39'h200)));
        check("t1_push2_v",    64'(top_v_o), 64'h1);
        pop();
        check("t1_pop1_top", 64'(top_addr_o), 64'h100);
        pop();
        check("t1_pop2_v",   64'(top_v_o),    64'h0);
        check("t1_pop2_top", 64'(top_addr_o), 64'h0);
        pop();
        check("t1_underflow_ckpt", 64'(ckpt_o), 64'h0);

        // 2. overflow drops the oldest entry
        push(39'h10); push(39'h20); push(39'h30); push(39'h40); push(39'h50);
        check("t2_full_ckpt", 64'(ckpt_o), 64'(mk(4, 1, 39'h50)));
        pop();
        check("t2_pop1_top", 64'(top_addr_o), 64'h40);
        pop();
        check("t2_pop2_top", 64'(top_addr_o), 64'h30);
        pop();
        check("t2_pop3_top", 64'(top_addr_o), 64'h20);
        pop();
        check("t2_empty_ckpt", 64'(ckpt_o), 64'(mk(0, 1, 39'h0)));

        // 3. simultaneous push+pop
        push(39'h10); push(39'h20);
        op(1'b1, 1'b1, 1'b0, 39'h99, '0);
        check("t3_replace_ckpt", 64'(ckpt_o), 64'(mk(2, 3, 39'h99)));
        pop();
        check("t3_below_replace", 64'(top_addr_o), 64'h10);
        pop();
        op(1'b1, 1'b1, 1'b0, 39'h99, '0);
        check("t3_empty_replace_ckpt", 64'(ckpt_o), 64'(mk(1, 2, 39'h99)));
        pop();
        check("t3_drained_v", 64'(top_v_o), 64'h0);

        // 4. checkpoint repair of a wrong-path overwrite
        push(39'h10); push(39'h20);
        saved_ckpt = ckpt_o;
        check("t4_ckpt_value", 64'(saved_ckpt), 64'(mk(2, 3, 39'h20)));
        pop();
        push(39'hBAD);
        check("t4_wrong_path_top", 64'(top_addr_o), 64'hBAD);
        op(1'b0, 1'b0, 1'b1, '0, mk(2, 3, 39'h20));
        check("t4_restored_ckpt", 64'(ckpt_o), 64'(mk(2, 3, 39'h20)));
        pop();
        check("t4_pop_after_restore", 64'(top_addr_o), 64'h10);

        // 5. restore wins over push and pop in the same cycle
        op(1'b1, 1'b1, 1'b1, 39'h77, mk(2, 3, 39'h20));
        check("t5_priority_ckpt", 64'(ckpt_o), 64'(mk(2, 3, 39'h20)));
        pop();
        check("t5_push_not_written", 64'(top_addr_o), 64'h10);

        // 6. asynchronous reset between edges
        push(39'h30); push(39'h35);
        check("t6_pre_reset_ckpt", 64'(ckpt_o), 64'(mk(3, 0, 39'h35)));
        push_v_i = 1'b1;
        push_addr_i = 39'h66;
        #2;
        reset_n_i = 1'b0;
        #1;
        check("t6_async_top",  64'(top_addr_o), 64'h0);
        check("t6_async_v",    64'(top_v_o),    64'h0);
        check("t6_async_ckpt", 64'(ckpt_o),     64'h0);
        push_v_i = 1'b0;
        push_addr_i = '0;
        @(posedge clk_i);
        #1;
        check("t6_held_ckpt", 64'(ckpt_o), 64'h0);
        reset_n_i = 1'b1;
        push(39'h40);
        check("t6_post_reset_ckpt", 64'(ckpt_o), 64'(mk(1, 1, 39'h40)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
